// File: rtl/exp_sequencer.sv
// ---------------------------------------------------------------------------
// exp_sequencer
//
// Purpose:
//    Drives one shared Montgomery multiplier through a left-to-right
//    square-and-multiply exponentiation, result = x^e mod m.
//    The multiplier computes MM(a, b) = a*b*R^-1 mod m with R = 2^WIDTH.
//    Operation list for one exponentiation:
//       INIT  : Xm = MM(x, r2)
//       for i = t downto 0 : A = MM(A, A); if e[i] then A = MM(A, Xm)
//       FINAL : A = MM(A, 1)
//    Only one multiplication is in flight at a time. Its operands stay
//    registered and stable until the multiplier reports completion.
//
// Parameters:
//    WIDTH  operand / modulus width in bits
//    TW     width of the top-bit index t (2^TW >= WIDTH)
//
// Ports:
//    clk         clock, all logic on the rising edge
//    reset       synchronous, active-high
//    start       begin an exponentiation (sampled only while idle)
//    in_x        base, less than m
//    in_e        exponent
//    in_t        index of the highest exponent bit processed
//    in_r        R mod m (Montgomery form of 1)
//    in_r2       R^2 mod m
//    busy        high while an exponentiation is running
//    done        one-cycle pulse, result valid
//    result      x^e mod m, held until the next accepted start
//    mul_start   one-cycle pulse launching a multiplication
//    mul_a       multiplier operand A
//    mul_b       multiplier operand B
//    mul_done    multiplier completion pulse
//    mul_result  multiplier product, valid with mul_done
// ---------------------------------------------------------------------------
module exp_sequencer #(
   parameter int WIDTH = 1024,
   parameter int TW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_e,
   input  logic [TW-1:0]    in_t,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_r2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_INIT,
      PH_SQR,
      PH_MUL,
      PH_FINAL
   } phase_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   state_t           state_next;
   phase_t           phase;
   phase_t           phase_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] xm_reg;
   logic [WIDTH-1:0] e_reg;
   logic [TW-1:0]    i_reg;

   logic             accept;
   logic             retire;
   logic [WIDTH-1:0] a_upd;
   logic [WIDTH-1:0] xm_upd;
   logic [TW-1:0]    i_next;
   logic [WIDTH-1:0] op_a_next;
   logic [WIDTH-1:0] op_b_next;
   logic             bit_set;
   logic             last_bit;

   // State register. Reset drops straight back to idle, which also
   // abandons any multiplication still in flight; a late mul_done then
   // arrives while idle and is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control outputs. busy covers ISSUE and WAIT only, so
   // it falls in the same cycle done pulses. mul_done is looked at only in
   // WAIT, so stray completions in any other state have no effect.
   always_comb begin
      state_next = state;
      mul_start  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      retire     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mul_start  = 1'b1;
            busy       = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (mul_done) begin
               retire     = 1'b1;
               state_next = (phase == PH_FINAL) ? S_DONE : S_ISSUE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Operation sequencing, evaluated for the multiplication that is
   // retiring. The product lands in Xm for INIT and in A otherwise; the
   // *_upd values are those registers as they will be after this edge, so
   // the next operation's operands can be loaded on the same edge and are
   // already valid in the following ISSUE cycle. The index only steps down
   // when the current bit is finished and is not zero, so bit 0 always
   // hands over to FINAL instead of wrapping into another iteration.
   always_comb begin
      a_upd      = (phase == PH_INIT) ? a_reg : mul_result;
      xm_upd     = (phase == PH_INIT) ? mul_result : xm_reg;
      bit_set    = e_reg[i_reg];
      last_bit   = (i_reg == '0);
      phase_next = phase;
      i_next     = i_reg;
      op_a_next  = a_upd;
      op_b_next  = a_upd;
      case (phase)
         PH_INIT: begin
            phase_next = PH_SQR;
         end
         PH_SQR: begin
            if (bit_set) begin
               phase_next = PH_MUL;
            end else if (last_bit) begin
               phase_next = PH_FINAL;
            end else begin
               phase_next = PH_SQR;
               i_next     = i_reg - TW'(1);
            end
         end
         PH_MUL: begin
            if (last_bit) begin
               phase_next = PH_FINAL;
            end else begin
               phase_next = PH_SQR;
               i_next     = i_reg - TW'(1);
            end
         end
         default: begin
            phase_next = PH_FINAL;
         end
      endcase
      case (phase_next)
         PH_MUL: begin
            op_a_next = a_upd;
            op_b_next = xm_upd;
         end
         PH_FINAL: begin
            op_a_next = a_upd;
            op_b_next = ONE;
         end
         default: begin
            op_a_next = a_upd;
            op_b_next = a_upd;
         end
      endcase
   end

   // Datapath registers. x and r2 are only ever used as the INIT operands,
   // so on accept they go straight into mul_a/mul_b rather than into
   // private copies; the in_* inputs are not looked at again after this
   // edge. Operands change only on accept or when a multiplication retires,
   // which keeps them stable across the whole WAIT. The FINAL product is
   // the answer and goes to result on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase  <= PH_INIT;
         a_reg  <= '0;
         xm_reg <= '0;
         e_reg  <= '0;
         i_reg  <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         result <= '0;
      end else if (accept) begin
         phase <= PH_INIT;
         a_reg <= in_r;
         e_reg <= in_e;
         i_reg <= in_t;
         mul_a <= in_x;
         mul_b <= in_r2;
      end else if (retire) begin
         a_reg  <= a_upd;
         xm_reg <= xm_upd;
         phase  <= phase_next;
         i_reg  <= i_next;
         if (phase == PH_FINAL) begin
            result <= mul_result;
         end else begin
            mul_a <= op_a_next;
            mul_b <= op_b_next;
         end
      end
   end

endmodule
